// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial transmitter and its matching receiver:
// state encoding, line levels and the even-parity helper.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Words are zero-extended to this width before parity; zeros do not change XOR.
  localparam int PAR_MAX_W = 64;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYC-1 and strobes on the last (and
// second-to-last) cycle of each bit. Held at zero while inClr is high.
module serial_bit_timer #(
  parameter int BIT_CYC = 4
) (
  input  logic inClk,
  input  logic inClr,
  output logic outBitEnd,
  output logic outBitPreEnd
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] PRE_LAST_CYC = (BIT_CYC > 1) ? CW'(BIT_CYC - 2) : '0;

  logic [CW-1:0] cyc_q;
  logic [CW-1:0] cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (inClr || (cyc_q == LAST_CYC)) begin
      cyc_d = '0;
    end else begin
      cyc_d = cyc_q + CW'(1);
    end
  end

  always_ff @(posedge inClk) begin
    cyc_q <= cyc_d;
  end

  assign outBitEnd    = (cyc_q == LAST_CYC);
  // Lets the FSM register outDone so it lands on the final cycle of STOP.
  assign outBitPreEnd = (BIT_CYC > 1) && (cyc_q == PRE_LAST_CYC);

endmodule

// File: rtl/serial_tx_frame.sv
// Framed serial transmitter: start bit, DATA_W bits LSB-first, optional even
// parity (SERIAL_TX_FRAME_PARITY_EN), stop bit. All outputs are registered.
module serial_tx_frame
  import serial_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 4
) (
  input  logic              inClk,
  input  logic              inRst,
  input  logic [DATA_W-1:0] inData,
  input  logic              inValid,
  output logic              outReady,
  output logic              outSer,
  output logic              outBusy,
  output logic              outDone,
  output tx_state_t         outDbgState
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nx;
  logic [BW-1:0]     bit_q;
  logic              ser_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
`ifdef SERIAL_TX_FRAME_PARITY_EN
  logic              par_q;
`endif

  logic tmr_clr;
  logic bit_end;
  logic bit_pre_end;

  // Timer is held cleared in IDLE so the first START cycle is cycle 0 of a bit.
  assign tmr_clr  = inRst || (state_q == ST_IDLE);
  assign shift_nx = shift_q >> 1;

  serial_bit_timer #(
    .BIT_CYC(BIT_CYC)
  ) u_timer (
    .inClk       (inClk),
    .inClr       (tmr_clr),
    .outBitEnd   (bit_end),
    .outBitPreEnd(bit_pre_end)
  );

  // Handshake: a word transfers on any rising edge where inValid and outReady are
  // both high; outReady is high only in IDLE, so inValid/inData are ignored while busy.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      ser_q   <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_FRAME_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (inValid) begin
            shift_q <= inData;
`ifdef SERIAL_TX_FRAME_PARITY_EN
            par_q   <= even_parity(PAR_MAX_W'(inData));
`endif
            bit_q   <= '0;
            state_q <= ST_START;
            ser_q   <= LINE_START;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            ser_q   <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_q == LAST_BIT) begin
`ifdef SERIAL_TX_FRAME_PARITY_EN
              state_q <= ST_PARITY;
              ser_q   <= par_q;
`else
              state_q <= ST_STOP;
              ser_q   <= LINE_IDLE;
              done_q  <= (BIT_CYC == 1);
`endif
            end else begin
              shift_q <= shift_nx;
              ser_q   <= shift_nx[0];
              bit_q   <= bit_q + BW'(1);
            end
          end
        end
`ifdef SERIAL_TX_FRAME_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            ser_q   <= LINE_IDLE;
            done_q  <= (BIT_CYC == 1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            state_q <= ST_IDLE;
            ser_q   <= LINE_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (bit_pre_end) begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ser_q   <= LINE_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign outReady    = ready_q;
  assign outSer      = ser_q;
  assign outBusy     = busy_q;
  assign outDone     = done_q;
  assign outDbgState = state_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: three instances (BIT_CYC 4, 1, 2), per-cycle
// scoreboard of {ser,busy,ready,done}, mid-bit sampling receiver.
module tb_serial_tx_frame;
  import serial_pkg::*;

`ifdef SERIAL_TX_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NLEV = PAR_EN ? 11 : 10;
  localparam logic [3:0] IDLE_OBS = 4'b1010;  // ser=1 busy=0 ready=1 done=0

  logic clk;
  logic       rst   [3];
  logic       valid [3];
  logic [7:0] din   [3];
  logic       ready [3];
  logic       ser   [3];
  logic       busy  [3];
  logic       done  [3];
  tx_state_t  dbg   [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];
  logic [7:0] wq[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] lv;   // line level per bit, bit 0 = start bit
    logic       par;
  } vec_t;
  vec_t tbl[6];

  serial_tx_frame #(.DATA_W(8), .BIT_CYC(4)) dut0 (
    .inClk(clk), .inRst(rst[0]), .inData(din[0]), .inValid(valid[0]),
    .outReady(ready[0]), .outSer(ser[0]), .outBusy(busy[0]), .outDone(done[0]),
    .outDbgState(dbg[0]));
  serial_tx_frame #(.DATA_W(8), .BIT_CYC(1)) dut1 (
    .inClk(clk), .inRst(rst[1]), .inData(din[1]), .inValid(valid[1]),
    .outReady(ready[1]), .outSer(ser[1]), .outBusy(busy[1]), .outDone(done[1]),
    .outDbgState(dbg[1]));
  serial_tx_frame #(.DATA_W(8), .BIT_CYC(2)) dut2 (
    .inClk(clk), .inRst(rst[2]), .inData(din[2]), .inValid(valid[2]),
    .outReady(ready[2]), .outSer(ser[2]), .outBusy(busy[2]), .outDone(done[2]),
    .outDbgState(dbg[2]));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic int bc_of(input int sel);
    case (sel)
      0: return 4;
      1: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] obs(input int sel);
    return {ser[sel], busy[sel], ready[sel], done[sel]};
  endfunction

  function automatic logic [10:0] mk_levels(input logic [9:0] lv, input logic par);
    return PAR_EN ? {1'b1, par, lv[8:0]} : {1'b0, lv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Driver + scoreboard for one frame; ends in the first idle cycle after it.
  task automatic run_frame(input int sel, input logic [7:0] data, input logic [9:0] lv,
                           input logic par, input logic keep, input logic [7:0] next);
    logic [10:0] levels;
    logic [3:0]  e;
    logic [3:0]  o;
    logic [7:0]  rx;
    logic [7:0]  wexp;
    int bc;
    int f;
    bc = bc_of(sel);
    f = NLEV * bc;
    levels = mk_levels(lv, par);
    check("ready_before_frame", {4'b0, obs(sel)}, {4'b0, IDLE_OBS});
    valid[sel] = 1'b1;
    din[sel] = data;
    wq.push_back(data);
    for (int i = 0; i < f; i++) exp_q.push_back({levels[i / bc], 1'b1, 1'b0, (i == f - 1)});
    tick();
    din[sel] = next;
    valid[sel] = keep;
    rx = '0;
    for (int i = 0; i < f; i++) begin
      o = obs(sel);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 4'bxxxx;
      check("frame_cycle", {4'b0, o}, {4'b0, e});
      if ((i % bc) == (bc / 2) && (i / bc) >= 1 && (i / bc) <= 8) rx[(i / bc) - 1] = o[3];
      tick();
    end
    check("idle_after_frame", {4'b0, obs(sel)}, {4'b0, IDLE_OBS});
    wexp = (wq.size() > 0) ? wq.pop_front() : 8'hxx;
    check("rx_word", rx, wexp);
  endtask

  initial begin
    logic [9:0]  lv3c;
    logic [7:0]  d;
    tbl[0] = '{8'hA5, 10'h34A, 1'b0};
    tbl[1] = '{8'h3C, 10'h278, 1'b0};
    tbl[2] = '{8'h00, 10'h200, 1'b0};
    tbl[3] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[4] = '{8'h01, 10'h202, 1'b1};
    tbl[5] = '{8'h80, 10'h300, 1'b1};

    for (int s = 0; s < 3; s++) begin
      rst[s] = 1'b1;
      valid[s] = 1'b0;
      din[s] = 8'h00;
    end
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      check("reset_obs", {4'b0, obs(s)}, {4'b0, IDLE_OBS});
      check("reset_state", {5'b0, dbg[s]}, {5'b0, ST_IDLE});
    end
    for (int s = 0; s < 3; s++) rst[s] = 1'b0;
    tick();

    // Long idle with inValid low
    for (int i = 0; i < 50; i++) begin
      check("idle_no_valid", {4'b0, obs(0)}, {4'b0, IDLE_OBS});
      tick();
    end

    // Table-driven frames at BIT_CYC=4
    for (int k = 0; k < 6; k++) run_frame(0, tbl[k].data, tbl[k].lv, tbl[k].par, 1'b0, 8'($urandom));

    // Back-to-back at BIT_CYC=1, inValid held, inData changed mid-frame
    run_frame(1, 8'h00, 10'h200, 1'b0, 1'b1, 8'hFF);
    run_frame(1, 8'hFF, 10'h3FE, 1'b0, 1'b0, 8'h5A);

    // Parity-relevant words at BIT_CYC=2
    run_frame(2, 8'h07, 10'h20E, 1'b1, 1'b0, 8'($urandom));
    run_frame(2, 8'hA5, 10'h34A, 1'b0, 1'b0, 8'($urandom));

    // Reset in the middle of a 3C frame
    lv3c = 10'h278;
    check("ready_before_rst_frame", {4'b0, obs(0)}, {4'b0, IDLE_OBS});
    valid[0] = 1'b1;
    din[0] = 8'h3C;
    tick();
    valid[0] = 1'b0;
    din[0] = 8'($urandom);
    for (int k = 1; k <= 15; k++) begin
      check("pre_rst_cycle", {4'b0, obs(0)}, {4'b0, lv3c[(k - 1) / 4], 3'b100});
      if (k < 15) tick();
    end
    rst[0] = 1'b1;
    tick();
    check("rst_mid_obs", {4'b0, obs(0)}, {4'b0, IDLE_OBS});
    check("rst_mid_state", {5'b0, dbg[0]}, {5'b0, ST_IDLE});
    rst[0] = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      check("post_rst_idle", {4'b0, obs(0)}, {4'b0, IDLE_OBS});
    end
    run_frame(0, 8'h3C, 10'h278, 1'b0, 1'b0, 8'($urandom));

    // Random words through the mid-bit receiver
    for (int k = 0; k < 100; k++) begin
      d = 8'($urandom_range(0, 255));
      run_frame(0, d, {1'b1, d, 1'b0}, ^d, 1'b0, 8'($urandom));
    end

    check("scoreboard_empty", 8'(exp_q.size() + wq.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
